booth_r4_mult_seq: RTL
======================

# booth_r4_mult_seq

Parametrised, self-sequencing radix-4 Booth multiplier with a ready/valid start interface, signed/unsigned mode select, full 2·WIDTH-bit product and an overflow flag. It is the next-generation multiply unit for the ALU/execute stage. An internal iteration counter and an FSM replace externally driven counter and clear strobes. Operands are captured on a single start handshake, and the result is held stable until the next accepted start.

## Interface
- WIDTH, 32: operand width. Must be even and ≥ 4.
- N (localparam), WIDTH/2+1: number of Booth iterations.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; forces IDLE and clears all outputs.
- start  in  1  request; accepted only when ready=1.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled on accept.
- operand_a  in  WIDTH  multiplicand; sampled on accept.
- operand_b  in  WIDTH  multiplier; sampled on accept.
- ready  out  1  high only in IDLE.
- result_valid  out  1  one-cycle pulse, high during DONE.
- result_lo  out  WIDTH  low half of the product.
- result_hi  out  WIDTH  high half of the product.
- data_exception  out  1  the product does not fit in WIDTH bits under the captured mode.

## Operation
- FSM has three states.
  - IDLE: ready=1. On start, go to RUN.
  - RUN: runs exactly N iterations, then goes to DONE.
  - DONE: result_valid=1. Go to IDLE unconditionally.
- On accept:
  - Extend operand_a and operand_b to WIDTH+2 bits: sign-extend if is_signed, zero-extend otherwise.
  - Load accumulator hi = 0.
  - Load lo = extended operand_b, with appended bit q[-1] = 0.
  - Iteration counter = 0.
  - Latch the mode bit.
- Per RUN iteration, decode lo[1:0],q[-1] into a Booth digit:
  - 000/111 → 0
  - 001/010 → +A
  - 011 → +2A
  - 100 → −2A
  - 101/110 → −A
- Add/subtract the digit into the (WIDTH+3)-bit hi part. One extra guard bit keeps ±2A sign-correct.
- Arithmetic-shift {hi, lo, q[-1]} right by 2. Increment the counter.
- After N iterations, the low 2·WIDTH bits of the accumulator product form the exact product, in both modes.
- On the edge RUN→DONE, register the outputs:
  - result_lo = product[WIDTH-1:0]
  - result_hi = product[2·WIDTH-1:WIDTH]
  - data_exception:
    - signed: 1 unless every bit of result_hi equals result_lo[WIDTH-1]
    - unsigned: 1 iff result_hi ≠ 0
- Output registers hold their values through IDLE until the next RUN→DONE edge. They are not cleared on accept.
- start while ready=0 is ignored. It is not queued, and the captured operands are unchanged.
- Operand/mode changes after accept have no effect on the in-flight operation.

## Timing
- Reset value of every output:
  - ready = 1 (IDLE)
  - result_valid = 0
  - result_lo = 0
  - result_hi = 0
  - data_exception = 0
- Reset has priority over start and over any FSM transition.
- Reset asserted mid-RUN or in DONE: next state is IDLE, outputs are cleared, and no result_valid pulse occurs.
- Start accepted at edge 0:
  - Edges 1..N perform the iterations.
  - Outputs are written at edge N.
  - result_valid is high for exactly one cycle, after edge N.
  - ready returns high after edge N+1.
- Latency: start edge → result_valid = N cycles (17 for WIDTH=32).
- Throughput: one op per N+2 cycles.
- Start asserted in the same cycle that ready rises (after edge N+1) is accepted at edge N+2.
- The counter width is clog2(N+1). No wrap occurs, because RUN exits on count == N-1 at the N-th iteration edge.

## Test plan
- WIDTH=32, signed, 7 × 0xFFFFFFFD → result_hi=0xFFFFFFFF, result_lo=0xFFFFFFEB, data_exception=0.
  - result_valid rises exactly 17 cycles after the start edge and lasts 1 cycle.
- WIDTH=32, unsigned, 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, exc=1.
- Same operands signed → hi=0, lo=1, exc=0.
- WIDTH=32, signed, 0x80000000 × 0xFFFFFFFF → hi=0x00000000, lo=0x80000000, exc=1.
- Hold start high with new operands during RUN → the pending op completes with the original operands.
  - The second request is accepted only after ready returns.
- Assert reset on RUN iteration 5 → next cycle ready=1 and all outputs 0, with no result_valid pulse.
  - A subsequent op of 3 × 5 unsigned → lo=15, hi=0, exc=0.
- WIDTH=8 (N=5), signed, 0x7F × 0x80 → hi=0xC0, lo=0x80, exc=1, with result_valid 5 cycles after start.

Source files
------------

// File: rtl/booth_r4_mult_seq.sv
// booth_r4_mult_seq
// Sequential radix-4 Booth multiplier with a ready/valid start handshake.
// One operand pair is captured per accepted start; the full 2*WIDTH-bit
// product is produced WIDTH/2+1 iterations later and held until the next
// result is written.
//
// Ports:
//   clock          : single clock, rising edge
//   reset          : synchronous, active-high
//   start          : request, accepted only while ready=1
//   is_signed      : 1 = two's-complement operands, 0 = unsigned
//   operand_a      : multiplicand
//   operand_b      : multiplier
//   ready          : high only in IDLE
//   result_valid   : one-cycle pulse while the result is fresh (DONE)
//   result_lo      : low WIDTH bits of the product
//   result_hi      : high WIDTH bits of the product
//   data_exception : product does not fit in WIDTH bits under the captured mode
//
// WIDTH must be even and at least 4.
module booth_r4_mult_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             ready,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             data_exception
);

  // Iteration count, extended operand width, accumulator-high width
  // (one guard bit above the extended multiplicand so +/-2A stays exact),
  // product width and counter width.
  localparam int unsigned N      = WIDTH / 2 + 1;
  localparam int unsigned EW     = WIDTH + 2;
  localparam int unsigned HW     = WIDTH + 3;
  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned CW     = $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [HW-1:0]   mcand;        // multiplicand, extended to accumulator width
  logic [HW-1:0]   acc_hi;
  logic [EW-1:0]   acc_lo;
  logic            q_m1;         // Booth appended bit q[-1]
  logic [CW-1:0]   iter_cnt;
  logic            mode_signed;  // mode latched on accept

  // Operand extension applied at accept time.
  logic [HW-1:0]   ext_a;
  logic [EW-1:0]   ext_b;

  always_comb begin
    if (is_signed) begin
      ext_a = {{3{operand_a[WIDTH-1]}}, operand_a};
      ext_b = {{2{operand_b[WIDTH-1]}}, operand_b};
    end else begin
      ext_a = {3'b000, operand_a};
      ext_b = {2'b00, operand_b};
    end
  end

  // Booth digit decode: magnitude (A or 2A) and sign from lo[1:0],q[-1].
  logic [HW-1:0]   digit_mag;
  logic            digit_neg;

  always_comb begin
    digit_mag = '0;
    digit_neg = 1'b0;
    case ({acc_lo[1:0], q_m1})
      3'b001, 3'b010: digit_mag = mcand;
      3'b011:         digit_mag = mcand << 1;
      3'b100: begin
        digit_mag = mcand << 1;
        digit_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        digit_mag = mcand;
        digit_neg = 1'b1;
      end
      default:        digit_mag = '0;
    endcase
  end

  // Partial-product add/subtract followed by a 2-bit arithmetic right shift
  // of {hi, lo, q[-1]}.
  logic [HW-1:0]   sum_hi;
  logic [HW-1:0]   nxt_hi;
  logic [EW-1:0]   nxt_lo;
  logic            nxt_q;

  always_comb begin
    if (digit_neg) begin
      sum_hi = acc_hi - digit_mag;
    end else begin
      sum_hi = acc_hi + digit_mag;
    end
    nxt_hi = {{2{sum_hi[HW-1]}}, sum_hi[HW-1:2]};
    nxt_lo = {sum_hi[1:0], acc_lo[EW-1:2]};
    nxt_q  = acc_lo[1];
  end

  // Product view of the post-iteration accumulator; only meaningful on the
  // final iteration, where it is exact in both modes.
  logic [PW-1:0]    product;
  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH-1:0] prod_hi;
  logic             prod_exc;

  always_comb begin
    product = {nxt_hi[WIDTH-3:0], nxt_lo};
    prod_lo = product[WIDTH-1:0];
    prod_hi = product[PW-1:WIDTH];
    if (mode_signed) begin
      prod_exc = (prod_hi != {WIDTH{prod_lo[WIDTH-1]}});
    end else begin
      prod_exc = (prod_hi != '0);
    end
  end

  logic last_iter;
  assign last_iter = (iter_cnt == CW'(N - 1));

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      mcand          <= '0;
      acc_hi         <= '0;
      acc_lo         <= '0;
      q_m1           <= 1'b0;
      iter_cnt       <= '0;
      mode_signed    <= 1'b0;
      ready          <= 1'b1;
      result_valid   <= 1'b0;
      result_lo      <= '0;
      result_hi      <= '0;
      data_exception <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand       <= ext_a;
            acc_hi      <= '0;
            acc_lo      <= ext_b;
            q_m1        <= 1'b0;
            iter_cnt    <= '0;
            mode_signed <= is_signed;
            ready       <= 1'b0;
            state       <= ST_RUN;
          end
        end

        ST_RUN: begin
          acc_hi   <= nxt_hi;
          acc_lo   <= nxt_lo;
          q_m1     <= nxt_q;
          iter_cnt <= iter_cnt + CW'(1);
          if (last_iter) begin
            result_lo      <= prod_lo;
            result_hi      <= prod_hi;
            data_exception <= prod_exc;
            result_valid   <= 1'b1;
            state          <= ST_DONE;
          end
        end

        ST_DONE: begin
          result_valid <= 1'b0;
          ready        <= 1'b1;
          state        <= ST_IDLE;
        end

        default: begin
          result_valid <= 1'b0;
          ready        <= 1'b1;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
